// File: rtl/mul_share_arbiter_if.sv
// Signal bundle between the requesters, the shared multiplier core and the result consumer.
// The slave modport is the arbiter's view and the master modport is the environment's view.
interface mul_share_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 14
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*DATA_W-1:0] req_a;
   logic [NUM_REQ*DATA_W-1:0] req_b;
   logic                      mul_ce;
   logic [DATA_W-1:0]         mul_din0;
   logic [DATA_W-1:0]         mul_din1;
   logic [DATA_W-1:0]         mul_dout;
   logic                      rsp_valid;
   logic                      rsp_ready;
   logic [ID_W-1:0]           rsp_id;
   logic [DATA_W-1:0]         rsp_data;

   modport slave (
      input  req_valid, req_a, req_b, mul_dout, rsp_ready,
      output req_ready, mul_ce, mul_din0, mul_din1, rsp_valid, rsp_id, rsp_data
   );

   modport master (
      output req_valid, req_a, req_b, mul_dout, rsp_ready,
      input  req_ready, mul_ce, mul_din0, mul_din1, rsp_valid, rsp_id, rsp_data
   );
endinterface

// File: rtl/mul_share_arbiter.sv
// Shares one ce-gated pipelined multiplier among NUM_REQ requesters, tracking ids in a shadow pipe.
// Define MUL_SHARE_ARB_FIXED_PRIO_EN for fixed lowest-index priority; round-robin by default.
module mul_share_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 14,
   parameter int MUL_LAT = 3
) (
   input logic                clk,
   input logic                reset,
   mul_share_arbiter_if.slave bus
);
   localparam int ID_W = $clog2(NUM_REQ);
   localparam int TAIL = MUL_LAT - 1;

   logic               mulCe;
   logic               grantVld;
   logic [ID_W-1:0]    grantId;
   logic [ID_W-1:0]    searchBase;
   logic [MUL_LAT-1:0] pipeVld_q;
   logic [MUL_LAT-1:0] pipeVld_d;
   logic [ID_W-1:0]    pipeId_q [MUL_LAT];
   logic [ID_W-1:0]    pipeId_d [MUL_LAT];
   logic [DATA_W-1:0]  opA_q;
   logic [DATA_W-1:0]  opA_d;
   logic [DATA_W-1:0]  opB_q;
   logic [DATA_W-1:0]  opB_d;
   logic [DATA_W-1:0]  selA;
   logic [DATA_W-1:0]  selB;

   // Shadow valid bits are cleared during reset, so the core keeps flushing while reset is low
   assign mulCe      = !pipeVld_q[TAIL] || bus.rsp_ready;
   assign bus.mul_ce = mulCe;

`ifdef MUL_SHARE_ARB_FIXED_PRIO_EN
   assign searchBase = '0;
`else
   logic [ID_W-1:0] rrPtr_q;
   logic [ID_W-1:0] rrPtr_d;

   assign searchBase = rrPtr_q;

   always_comb begin
      rrPtr_d = rrPtr_q;
      if (grantVld) begin
         rrPtr_d = (grantId == ID_W'(NUM_REQ - 1)) ? '0 : grantId + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rrPtr_q <= '0;
      end else begin
         rrPtr_q <= rrPtr_d;
      end
   end
`endif

   // A grant is always a transfer: it is only raised for a valid requester while the core advances
   always_comb begin
      logic [ID_W-1:0] idx;
      grantVld = 1'b0;
      grantId  = '0;
      idx      = '0;
      if (mulCe && reset) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(searchBase) + k) % NUM_REQ);
            if (!grantVld && bus.req_valid[idx]) begin
               grantVld = 1'b1;
               grantId  = idx;
            end
         end
      end
   end

   always_comb begin
      bus.req_ready = '0;
      if (grantVld) begin
         bus.req_ready[grantId] = 1'b1;
      end
   end

   always_comb begin
      selA  = bus.req_a[int'(grantId) * DATA_W +: DATA_W];
      selB  = bus.req_b[int'(grantId) * DATA_W +: DATA_W];
      opA_d = opA_q;
      opB_d = opB_q;
      if (grantVld) begin
         opA_d = selA;
         opB_d = selB;
      end
   end

   assign bus.mul_din0 = grantVld ? selA : opA_q;
   assign bus.mul_din1 = grantVld ? selB : opB_q;

   always_comb begin
      pipeVld_d = pipeVld_q;
      pipeId_d  = pipeId_q;
      if (mulCe) begin
         pipeVld_d[0] = grantVld;
         pipeId_d[0]  = grantId;
         for (int s = 1; s < MUL_LAT; s++) begin
            pipeVld_d[s] = pipeVld_q[s-1];
            pipeId_d[s]  = pipeId_q[s-1];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pipeVld_q <= '0;
         for (int s = 0; s < MUL_LAT; s++) begin
            pipeId_q[s] <= '0;
         end
         opA_q <= '0;
         opB_q <= '0;
      end else begin
         pipeVld_q <= pipeVld_d;
         pipeId_q  <= pipeId_d;
         opA_q     <= opA_d;
         opB_q     <= opB_d;
      end
   end

   assign bus.rsp_valid = pipeVld_q[TAIL];
   assign bus.rsp_id    = pipeId_q[TAIL];
   assign bus.rsp_data  = bus.mul_dout;
endmodule
